// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I decode-stage types, encodings and ALU decode helper
package rv_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        branch;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } de_regs_t;

  // sub_sel is only meaningful for R-type; I-ALU passes 0 since bit 30 is immediate there.
  function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic sub_sel);
    case (funct3)
      3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv_reg_file.sv
// rtl/rv_reg_file.sv - 32x32 integer register file, two async reads, one sync write
// Optional write-to-read bypass: DECODE_RF_BYPASS_EN
module rv_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  always_comb begin
    rd1 = (a1 == 5'd0) ? 32'd0 : regs_q[a1];
    rd2 = (a2 == 5'd0) ? 32'd0 : regs_q[a2];
`ifdef DECODE_RF_BYPASS_EN
    if (we && (wa != 5'd0) && (wa == a1)) rd1 = wd;
    if (we && (wa != 5'd0) && (wa == a2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/rv_decode_cycle.sv
// rtl/rv_decode_cycle.sv - RV32I decode stage with D->E pipeline register
// Register-file bypass selected by DECODE_RF_BYPASS_EN (see rv_reg_file)
module rv_decode_cycle
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  imm_src_t    imm_src;
  logic [31:0] imm_ext;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  de_regs_t    de_d;
  de_regs_t    de_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];

  rv_reg_file u_rf (
    .clk (clk),
    .rst (rst),
    .a1  (InstrD[19:15]),
    .a2  (InstrD[24:20]),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  always_comb begin
    case (imm_src)
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  always_comb begin
    de_d          = '0;
    de_d.alu_ctrl = ALU_ADD;
    imm_src       = IMM_I;
    case (opcode)
      OP_LW: begin
        de_d.reg_write  = 1'b1;
        de_d.alu_src    = 1'b1;
        de_d.result_src = RES_MEM;
      end
      OP_SW: begin
        de_d.mem_write = 1'b1;
        de_d.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_R: begin
        de_d.reg_write = 1'b1;
        de_d.alu_ctrl  = alu_decode(funct3, InstrD[30]);
      end
      OP_IALU: begin
        de_d.reg_write = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.alu_ctrl  = alu_decode(funct3, 1'b0);
      end
      OP_BEQ: begin
        de_d.branch   = 1'b1;
        de_d.alu_ctrl = ALU_SUB;
        imm_src       = IMM_B;
      end
      default: ;
    endcase
    de_d.rd1      = rf_rd1;
    de_d.rd2      = rf_rd2;
    de_d.imm      = imm_ext;
    de_d.rd       = InstrD[11:7];
    de_d.rs1      = InstrD[19:15];
    de_d.rs2      = InstrD[24:20];
    de_d.pc       = PCD;
    de_d.pc_plus4 = PCPlus4D;
  end

  always_ff @(posedge clk) begin
    if (rst) de_q <= '0;
    else     de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign ALUSrcE     = de_q.alu_src;
  assign MemWriteE   = de_q.mem_write;
  assign BranchE     = de_q.branch;
  assign ResultSrcE  = de_q.result_src;
  assign ALUControlE = de_q.alu_ctrl;
  assign RD1_E       = de_q.rd1;
  assign RD2_E       = de_q.rd2;
  assign Imm_Ext_E   = de_q.imm;
  assign RD_E        = de_q.rd;
  assign RS1_E       = de_q.rs1;
  assign RS2_E       = de_q.rs2;
  assign PCE         = de_q.pc;
  assign PCPlus4E    = de_q.pc_plus4;

endmodule

// File: tb/tb_rv_decode_cycle.sv
// tb/tb_rv_decode_cycle.sv - directed self-checking bench for rv_decode_cycle
// Expectations follow DECODE_RF_BYPASS_EN when the bench is built with it.
module tb_rv_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  int n_vec  = 0;
  int n_miss = 0;

  rv_decode_cycle dut (
    .clk (clk), .rst (rst), .InstrD (InstrD), .PCD (PCD), .PCPlus4D (PCPlus4D),
    .RegWriteW (RegWriteW), .RDW (RDW), .ResultW (ResultW),
    .RegWriteE (RegWriteE), .ALUSrcE (ALUSrcE), .MemWriteE (MemWriteE), .BranchE (BranchE),
    .ResultSrcE (ResultSrcE), .ALUControlE (ALUControlE),
    .RD1_E (RD1_E), .RD2_E (RD2_E), .Imm_Ext_E (Imm_Ext_E),
    .RD_E (RD_E), .RS1_E (RS1_E), .RS2_E (RS2_E),
    .PCE (PCE), .PCPlus4E (PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".RegWriteE"},   {31'd0, RegWriteE},   32'd0);
    chk({tag, ".ALUSrcE"},     {31'd0, ALUSrcE},     32'd0);
    chk({tag, ".MemWriteE"},   {31'd0, MemWriteE},   32'd0);
    chk({tag, ".BranchE"},     {31'd0, BranchE},     32'd0);
    chk({tag, ".ResultSrcE"},  {30'd0, ResultSrcE},  32'd0);
    chk({tag, ".ALUControlE"}, {29'd0, ALUControlE}, 32'd0);
    chk({tag, ".RD1_E"},       RD1_E,                32'd0);
    chk({tag, ".RD2_E"},       RD2_E,                32'd0);
    chk({tag, ".Imm_Ext_E"},   Imm_Ext_E,            32'd0);
    chk({tag, ".RD_E"},        {27'd0, RD_E},        32'd0);
    chk({tag, ".RS1_E"},       {27'd0, RS1_E},       32'd0);
    chk({tag, ".RS2_E"},       {27'd0, RS2_E},       32'd0);
    chk({tag, ".PCE"},         PCE,                  32'd0);
    chk({tag, ".PCPlus4E"},    PCPlus4E,             32'd0);
  endtask

  task automatic chk_ctrl(input string tag, input logic [3:0] rw_as_mw_br,
                          input logic [1:0] rsrc, input logic [2:0] alu);
    chk({tag, ".ctrl"}, {28'd0, RegWriteE, ALUSrcE, MemWriteE, BranchE}, {28'd0, rw_as_mw_br});
    chk({tag, ".ResultSrcE"}, {30'd0, ResultSrcE}, {30'd0, rsrc});
    chk({tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, alu});
  endtask

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [2:0]  alu;
  } alu_vec_t;

  alu_vec_t alu_tab[7];

  initial begin
    alu_tab[0] = '{"sub",      r_enc(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 3'b001};
    alu_tab[1] = '{"slt",      r_enc(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd3), 3'b101};
    alu_tab[2] = '{"or",       r_enc(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd3), 3'b011};
    alu_tab[3] = '{"and",      r_enc(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3), 3'b010};
    alu_tab[4] = '{"sll_add",  r_enc(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd3), 3'b000};
    alu_tab[5] = '{"addi_b30", i_enc(12'h400, 5'd1, 3'b000, 5'd3, 7'b0010011), 3'b000};
    alu_tab[6] = '{"andi",     i_enc(12'h00F, 5'd1, 3'b111, 5'd3, 7'b0010011), 3'b010};

    rst = 1'b1; InstrD = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
    step();
    chk_all_zero("reset");

    // x1 written, read back, then cleared by a reset that collides with a writeback
    rst = 1'b0; RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h0000A5A5;
    step();
    RegWriteW = 1'b0; InstrD = r_enc(7'd0, 5'd1, 5'd1, 3'b000, 5'd3);
    step();
    chk("x1_written", RD1_E, 32'h0000A5A5);
    rst = 1'b1; RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h00001111;
    step();
    chk("rst_over_wb.RD1_E", RD1_E, 32'd0);
    rst = 1'b0; RegWriteW = 1'b0;
    step();
    chk("x1_after_rst", RD1_E, 32'd0);

    InstrD = 32'h12345678; PCD = 32'h51; PCPlus4D = 32'h52;
    step();
    chk("unsup.PCE", PCE, 32'h51);
    chk("unsup.PCPlus4E", PCPlus4E, 32'h52);
    chk("unsup.RD_E", {27'd0, RD_E}, 32'd12);
    chk("unsup.RS1_E", {27'd0, RS1_E}, 32'd8);
    chk("unsup.RS2_E", {27'd0, RS2_E}, 32'd3);
    chk_ctrl("unsup", 4'b0000, 2'b00, 3'b000);
    chk("unsup.Imm", Imm_Ext_E, 32'h00000123);
    chk("unsup.RD1_E", RD1_E, 32'd0);
    chk("unsup.RD2_E", RD2_E, 32'd0);

    InstrD = 32'h00700293;
    step();
    chk_ctrl("addi", 4'b1100, 2'b00, 3'b000);
    chk("addi.Imm", Imm_Ext_E, 32'd7);
    chk("addi.RD_E", {27'd0, RD_E}, 32'd5);

    InstrD = 32'h00528333; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
    step();
`ifdef DECODE_RF_BYPASS_EN
    chk("wb_same.RD1_E", RD1_E, 32'hDEADBEEF);
    chk("wb_same.RD2_E", RD2_E, 32'hDEADBEEF);
`else
    chk("wb_same.RD1_E", RD1_E, 32'd0);
    chk("wb_same.RD2_E", RD2_E, 32'd0);
`endif
    chk("wb_same.RD_E", {27'd0, RD_E}, 32'd6);
    RegWriteW = 1'b0;
    step();
    chk("wb_next.RD1_E", RD1_E, 32'hDEADBEEF);
    chk("wb_next.RD2_E", RD2_E, 32'hDEADBEEF);

    InstrD = r_enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd7);
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hCAFEF00D;
    step();
    chk("x0_same.RD1_E", RD1_E, 32'd0);
    chk("x0_same.RD2_E", RD2_E, 32'd0);
    RegWriteW = 1'b0;
    step();
    chk("x0_next.RD1_E", RD1_E, 32'd0);
    chk("x0_next.RD2_E", RD2_E, 32'd0);

    for (int i = 0; i < 7; i++) begin
      InstrD = alu_tab[i].instr;
      step();
      chk({alu_tab[i].tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, alu_tab[i].alu});
    end

    // lw x4,-2(x5): x5 still holds 0xDEADBEEF
    InstrD = i_enc(12'hFFE, 5'd5, 3'b010, 5'd4, 7'b0000011);
    step();
    chk_ctrl("lw", 4'b1100, 2'b01, 3'b000);
    chk("lw.Imm", Imm_Ext_E, 32'hFFFFFFFE);
    chk("lw.RD1_E", RD1_E, 32'hDEADBEEF);

    InstrD = 32'hFE512E23;
    step();
    chk_ctrl("sw", 4'b0110, 2'b00, 3'b000);
    chk("sw.Imm", Imm_Ext_E, 32'hFFFFFFFC);
    chk("sw.RD2_E", RD2_E, 32'hDEADBEEF);

    // beq x1,x2,-8 with imm[11] in bit 7
    InstrD = 32'hFE208CE3;
    step();
    chk_ctrl("beq", 4'b0001, 2'b00, 3'b001);
    chk("beq.Imm", Imm_Ext_E, 32'hFFFFFFF8);

    // same branch with bit 7 clear: imm[11]=0 while imm[12]=1
    InstrD = 32'hFE208C63;
    step();
    chk("beq_b7.Imm", Imm_Ext_E, 32'hFFFFF7F8);
    chk("beq_b7.BranchE", {31'd0, BranchE}, 32'd1);

    rst = 1'b1;
    step();
    chk_all_zero("rst_mid");

    rst = 1'b0; InstrD = 32'h00700293;
    chk("rst_release.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    step();
    chk("first_after_rst.RegWriteE", {31'd0, RegWriteE}, 32'd1);
    chk("first_after_rst.Imm", Imm_Ext_E, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
